// File: rtl/req_encoder_8to3_pkg.sv
// req_enc_pkg: shared types and defaults for the request encoder
package req_enc_pkg;
  typedef enum logic {IDLE, OFFER} req_enc_state_e;
  localparam int N_DEFAULT = 8;
endpackage

// File: rtl/req_encoder_8to3_if.sv
// req_encoder_8to3_if: request capture and code handshake bundle
interface req_encoder_8to3_if #(parameter int N = 8) ();
  localparam int W = $clog2(N);
  logic enable;
  logic [N-1:0] req_in;
  logic [W-1:0] code_out;
  logic code_valid;
  logic code_ready;
  logic [N-1:0] pending_out;
  logic overflow;
  modport master (output enable, req_in, code_ready, input code_out, code_valid, pending_out, overflow);
  modport slave (input enable, req_in, code_ready, output code_out, code_valid, pending_out, overflow);
endinterface

// File: rtl/req_encoder_8to3_pick.sv
// req_pick: combinational rotating- or fixed-priority picker over pending requests
module req_pick import req_enc_pkg::*; #(
  parameter int N = N_DEFAULT,
  parameter bit ROUND_ROBIN = 1,
  localparam int W = $clog2(N)
) (
  input logic [N-1:0] pending,
  input logic [W-1:0] last,
  output logic any,
  output logic [W-1:0] idx
);
  int j;
  always_comb begin
    any = |pending;
    idx = '0;
    j = 0;
    for (int k = N; k >= 1; k--) begin
      j = ROUND_ROBIN ? (int'(last) + k) % N : k - 1;
      if (pending[W'(j)]) idx = W'(j);
    end
  end
endmodule

// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3: captures multi-hot requests and issues them one index at a time over valid/ready
module req_encoder_8to3 import req_enc_pkg::*; #(
  parameter int N = N_DEFAULT,
  parameter bit ROUND_ROBIN = 1
) (
  input logic clk,
  input logic rst_n,
  req_encoder_8to3_if.slave bus
);
  localparam int W = $clog2(N);
  req_enc_state_e state, state_nx;
  logic [N-1:0] pending, pending_nx, taken, cap, held;
  logic [W-1:0] code, code_nx, last, pick_last, pick_idx;
  logic valid, ovf, ovf_nx, pick_any, accept, load;
  assign accept = valid && bus.code_ready;
  assign pick_last = accept ? code : last;
  req_pick #(.N(N), .ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .pending(pending),
    .last(pick_last),
    .any(pick_any),
    .idx(pick_idx)
  );
  always_comb begin
    load = pick_any && (state == IDLE || accept);
    state_nx = load ? OFFER : accept ? IDLE : state;
    code_nx = load ? pick_idx : code;
    taken = load ? N'(1) << pick_idx : '0;
    cap = bus.enable ? bus.req_in : '0;
    held = (valid && !bus.code_ready) ? N'(1) << code : '0;
    pending_nx = (pending & ~taken) | cap;
    ovf_nx = |(cap & ((pending & ~taken) | held));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      code <= '0;
      valid <= 1'b0;
      ovf <= 1'b0;
      last <= W'(N - 1);
    end else begin
      state <= state_nx;
      pending <= pending_nx;
      code <= code_nx;
      valid <= state_nx == OFFER;
      ovf <= ovf_nx;
      last <= pick_last;
    end
  end
  assign bus.code_out = code;
  assign bus.code_valid = valid;
  assign bus.pending_out = pending;
  assign bus.overflow = ovf;
endmodule
